turbosound_ctl: RTL and testbench
=================================

Name: turbosound_ctl

Overview:
- Controller sequencing the two AY-3-8912 PSGs whose A/B/C channels feed the stereo mixer.
- Decodes CPU I/O writes and reads on the AY ports (FFFD select/address, BFFD data) and implements Turbosound chip select.
- Issues single-cycle register write strobes to the selected PSG.
- After reset, runs an initialisation sequence that silences both PSGs before CPU traffic reaches them.

Parameters:
INIT_EN, 1, 1 = run the post-reset silence sequence; 0 = enter RUN directly
INIT_MIXER, 8'hFF, value written to PSG register 7 (tone/noise mixer) during init

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ce  in  1  PSG clock enable; all PSG write strobes occur only in cycles with ce=1
io_wr  in  1  one-cycle CPU I/O write strobe (already qualified by IORQ)
io_rd  in  1  CPU I/O read, level
addr  in  16  CPU address
d_in  in  8  CPU write data
d_out  out  8  read data: selected PSG's register value, or 8'hFF
d_oe  out  1  d_out valid (read of FFFD decoded)
ay_addr  out  4  register index presented to both PSGs
ay_wdata  out  8  write data presented to both PSGs
ay_we1  out  1  write strobe, PSG 1
ay_we2  out  1  write strobe, PSG 2
ay_rdata1  in  8  PSG 1 read data for ay_addr
ay_rdata2  in  8  PSG 2 read data for ay_addr
init_busy  out  1  high while the init sequence runs

Behaviour:
- Decode: select/address port when addr[15]=1, addr[14]=1, addr[1]=0. Data port when addr[15]=1, addr[14]=0, addr[1]=0. All other addresses are ignored.
- Write to the select port:
  - d_in=8'hFF: sel<=0 (PSG 1).
  - d_in=8'hFE: sel<=1 (PSG 2).
  - d_in[7:4]=0: reg_addr[sel]<=d_in[3:0], valid[sel]<=1.
  - Any other value: valid[sel]<=0.
  - Each PSG keeps its own latched address and valid bit. Select and address latches update in the strobe cycle, including during init.
- Write to the data port:
  - If valid[sel]=0, the write is ignored.
  - Otherwise it loads a one-deep pending buffer {chip, addr, data}, pend=1. A new data write while pend=1 overwrites the buffer (last wins).
- Issue: in the first cycle with ce=1 and pend=1 and state RUN:
  - ay_addr/ay_wdata take the buffer values.
  - ay_we1 or ay_we2 pulses for exactly 1 clock, per the buffered chip.
  - pend clears.
  - Latency: io_wr at cycle N gives the strobe at the first ce cycle ≥ N+1.
- Reads: d_oe = io_rd & select-port decode (combinational).
  - d_out = ay_rdata of sel when valid[sel]=1, else 8'hFF.
  - Outside write strobes, ay_addr is driven with reg_addr[sel].
- FSM states RESET_WAIT -> INIT -> RUN:
  - RESET_WAIT: one clock after reset release.
  - INIT: counter i runs 0..13, one step per ce cycle.
    - Each step: ay_addr=i, ay_wdata = INIT_MIXER if i=7, else 8'h00.
    - ay_we1 and ay_we2 assert together.
    - After i=13 the FSM goes to RUN. Registers 14/15 (I/O ports) are untouched.
  - RUN: normal issue path. A write pending at entry issues on the first RUN ce cycle.
  - INIT_EN=0: RESET_WAIT goes to RUN.
  - init_busy=1 in RESET_WAIT and INIT.
- Reset values: sel=0, reg_addr=0, valid=0, pend=0, ay_we1/2=0, ay_addr=0, ay_wdata=0, d_oe=0, d_out=8'hFF, init_busy=1 (0 when INIT_EN=0), state=RESET_WAIT.
- Reset asserted mid-init or mid-pend: everything returns to reset values immediately and the full sequence restarts.
- Simultaneous io_wr to the data port and an issue cycle: the issue uses the old buffer and the new write becomes pending. It is never lost.
- ce held low: strobes stall indefinitely and latches still update.

Decomposition:
- Shared package holds:
  - Port decode masks and constants: SEL_PORT, DATA_PORT, CHIP_SEL1=8'hFF, CHIP_SEL2=8'hFE.
  - Init constants: INIT_LAST=4'd13, MIXER_REG=4'd7.
  - The state enum {RESET_WAIT, INIT, RUN}.
- One natural sub-module: turbosound_init_seq. It contains the init FSM and counter, and outputs init_addr, init_data, init_we and busy. The top muxes its outputs with the pending-write path.

Test Plan:
- Reset release, ce every 4th clock -> 14 dual strobes with addr 0..13 and data 00 (addr 7 = FF); init_busy falls after the addr-13 strobe; no strobe on 14/15.
- RUN: write FFFD=FE, FFFD=08, BFFD=0F -> ay_we2 only, ay_addr=8, ay_wdata=0F, 1-clock pulse on the next ce.
- Write FFFD=FF, FFFD=03; read FFFD with ay_rdata1=5A -> d_oe=1, d_out=5A. Then FFFD=20 and read -> d_out=FF, and BFFD=11 produces no strobe.
- During init write FFFD=05, BFFD=AA, then BFFD=BB -> single ay_we1 addr 5 data BB on the first RUN ce cycle.
- Assert reset at init step 6 -> outputs return to reset values at once; after release the sequence restarts from addr 0.
- BFFD write in the same cycle as a pending issue -> old data strobes now and new data strobes on the next ce cycle.

Source files
------------

// File: rtl/turbosound_pkg.sv
// Shared constants and types for the Turbosound dual-AY controller.
// Port decode looks only at A15, A14 and A1.
package turbosound_pkg;

   localparam logic [15:0] PORT_MASK = 16'hC002;
   localparam logic [15:0] SEL_PORT  = 16'hC000;
   localparam logic [15:0] DATA_PORT = 16'h8000;

   localparam logic [7:0] CHIP_SEL1 = 8'hFF;
   localparam logic [7:0] CHIP_SEL2 = 8'hFE;

   localparam logic [3:0] INIT_LAST = 4'd13;
   localparam logic [3:0] MIXER_REG = 4'd7;

   typedef enum logic [1:0] {
      RESET_WAIT,
      INIT,
      RUN
   } ts_state_e;

endpackage

// File: rtl/turbosound_init_seq.sv
// Post-reset sequencer: silences registers 0..13 of both PSGs, one register
// per ce cycle, then hands the bus to the CPU path.
module turbosound_init_seq
   import turbosound_pkg::*;
#(
   parameter bit         INIT_EN    = 1'b1,
   parameter logic [7:0] INIT_MIXER = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   output logic [3:0] init_addr,
   output logic [7:0] init_data,
   output logic       init_we,
   output logic       busy,
   output logic       run
);

   ts_state_e  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_WAIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RESET_WAIT: state_d = INIT_EN ? INIT : RUN;
         INIT: begin
            if (ce) begin
               if (cnt_q == INIT_LAST) state_d = RUN;
               else                    cnt_d   = cnt_q + 4'd1;
            end
         end
         RUN:     state_d = RUN;
         default: state_d = RESET_WAIT;
      endcase
   end

   always_comb begin
      init_we   = (state_q == INIT) && ce;
      init_addr = cnt_q;
      init_data = (cnt_q == MIXER_REG) ? INIT_MIXER : '0;
      busy      = INIT_EN && (state_q != RUN);
      run       = (state_q == RUN);
   end

endmodule

// File: rtl/turbosound_ctl.sv
// Turbosound controller: CPU port decode, per-chip address latches, a one-deep
// pending write buffer, and the bus mux between init sequencer and CPU writes.
module turbosound_ctl
   import turbosound_pkg::*;
#(
   parameter bit         INIT_EN    = 1'b1,
   parameter logic [7:0] INIT_MIXER = 8'hFF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   input  logic        io_wr,
   input  logic        io_rd,
   input  logic [15:0] addr,
   input  logic [7:0]  d_in,
   output logic [7:0]  d_out,
   output logic        d_oe,
   output logic [3:0]  ay_addr,
   output logic [7:0]  ay_wdata,
   output logic        ay_we1,
   output logic        ay_we2,
   input  logic [7:0]  ay_rdata1,
   input  logic [7:0]  ay_rdata2,
   output logic        init_busy
);

   logic       sel_q, sel_d;
   logic [1:0][3:0] reg_addr_q, reg_addr_d;
   logic [1:0] valid_q, valid_d;
   logic       pend_q, pend_d;
   logic       pend_chip_q, pend_chip_d;
   logic [3:0] pend_addr_q, pend_addr_d;
   logic [7:0] pend_data_q, pend_data_d;

   logic [3:0] init_addr;
   logic [7:0] init_data;
   logic       init_we, run, issue, sel_hit, data_hit;

   turbosound_init_seq #(
      .INIT_EN    (INIT_EN),
      .INIT_MIXER (INIT_MIXER)
   ) u_init_seq (
      .clk       (clock),
      .rst_n     (reset),
      .ce        (ce),
      .init_addr (init_addr),
      .init_data (init_data),
      .init_we   (init_we),
      .busy      (init_busy),
      .run       (run)
   );

   assign sel_hit  = (addr & PORT_MASK) == SEL_PORT;
   assign data_hit = (addr & PORT_MASK) == DATA_PORT;
   assign issue    = run && ce && pend_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sel_q       <= 1'b0;
         reg_addr_q  <= '0;
         valid_q     <= '0;
         pend_q      <= 1'b0;
         pend_chip_q <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
      end else begin
         sel_q       <= sel_d;
         reg_addr_q  <= reg_addr_d;
         valid_q     <= valid_d;
         pend_q      <= pend_d;
         pend_chip_q <= pend_chip_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
      end
   end

   // A data write landing in an issue cycle re-arms the buffer after the old
   // contents have gone out, so it is never dropped.
   always_comb begin
      sel_d       = sel_q;
      reg_addr_d  = reg_addr_q;
      valid_d     = valid_q;
      pend_d      = pend_q;
      pend_chip_d = pend_chip_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      if (issue) pend_d = 1'b0;
      if (io_wr && sel_hit) begin
         if (d_in == CHIP_SEL1)      sel_d = 1'b0;
         else if (d_in == CHIP_SEL2) sel_d = 1'b1;
         else if (d_in[7:4] == 4'h0) begin
            reg_addr_d[sel_q] = d_in[3:0];
            valid_d[sel_q]    = 1'b1;
         end else begin
            valid_d[sel_q] = 1'b0;
         end
      end
      if (io_wr && data_hit && valid_q[sel_q]) begin
         pend_d      = 1'b1;
         pend_chip_d = sel_q;
         pend_addr_d = reg_addr_q[sel_q];
         pend_data_d = d_in;
      end
   end

   always_comb begin
      ay_we1   = 1'b0;
      ay_we2   = 1'b0;
      ay_addr  = reg_addr_q[sel_q];
      ay_wdata = '0;
      if (init_we) begin
         ay_we1   = 1'b1;
         ay_we2   = 1'b1;
         ay_addr  = init_addr;
         ay_wdata = init_data;
      end else if (issue) begin
         ay_we1   = !pend_chip_q;
         ay_we2   = pend_chip_q;
         ay_addr  = pend_addr_q;
         ay_wdata = pend_data_q;
      end
      d_oe  = io_rd && sel_hit;
      d_out = valid_q[sel_q] ? (sel_q ? ay_rdata2 : ay_rdata1) : 8'hFF;
   end

endmodule

// File: tb/tb_turbosound_ctl.sv
// Bench for turbosound_ctl: directed scenarios plus random CPU traffic, all
// outputs compared every cycle against a transaction-level model.
module tb_turbosound_ctl;

   localparam logic [7:0] MIX = 8'hFF;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ce = 1'b0, io_wr = 1'b0, io_rd = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0]  d_in = '0, ay_rdata1 = '0, ay_rdata2 = '0;
   logic [7:0]  d_out, ay_wdata;
   logic [3:0]  ay_addr;
   logic        d_oe, ay_we1, ay_we2, init_busy;

   turbosound_ctl #(
      .INIT_EN    (1'b1),
      .INIT_MIXER (MIX)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .ce        (ce),
      .io_wr     (io_wr),
      .io_rd     (io_rd),
      .addr      (addr),
      .d_in      (d_in),
      .d_out     (d_out),
      .d_oe      (d_oe),
      .ay_addr   (ay_addr),
      .ay_wdata  (ay_wdata),
      .ay_we1    (ay_we1),
      .ay_we2    (ay_we2),
      .ay_rdata1 (ay_rdata1),
      .ay_rdata2 (ay_rdata2),
      .init_busy (init_busy)
   );

   always #5 clock = ~clock;

   int n_pass = 0, n_total = 0;
   int ce_period = 4, tick = 0, init_strobes = 0;
   bit ce_rand = 0;

   // Model: m_step = -1 waiting after reset, 0..13 next init register, 14 = running.
   int         m_step;
   bit         m_sel;
   logic [3:0] m_ra [2];
   bit         m_val [2];
   bit         m_pend, m_pchip;
   logic [3:0] m_pa;
   logic [7:0] m_pd;

   function automatic bit is_sel(input logic [15:0] a);
      return a[15] && a[14] && !a[1];
   endfunction

   function automatic bit is_data(input logic [15:0] a);
      return a[15] && !a[14] && !a[1];
   endfunction

   task automatic model_reset();
      m_step = -1; m_sel = 0; m_ra[0] = 0; m_ra[1] = 0;
      m_val[0] = 0; m_val[1] = 0; m_pend = 0; m_pchip = 0; m_pa = 0; m_pd = 0;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic cyc();
      bit issue, e_we1, e_we2;
      logic [3:0] e_addr;
      logic [7:0] e_data, e_out;
      if (ce_rand)             ce = 1'($urandom_range(0, 1));
      else if (ce_period == 0) ce = 0;
      else                     ce = ((tick % ce_period) == ce_period - 1);
      tick++;
      ay_rdata1 = 8'($urandom);
      ay_rdata2 = 8'($urandom);
      @(negedge clock);
      issue  = (m_step == 14) && ce && m_pend;
      e_we1  = 0; e_we2 = 0; e_addr = m_ra[m_sel]; e_data = 8'h00;
      if (m_step >= 0 && m_step < 14 && ce) begin
         e_we1 = 1; e_we2 = 1; e_addr = 4'(m_step);
         e_data = (m_step == 7) ? MIX : 8'h00;
      end else if (issue) begin
         e_we1 = !m_pchip; e_we2 = m_pchip; e_addr = m_pa; e_data = m_pd;
      end
      e_out = m_val[m_sel] ? (m_sel ? ay_rdata2 : ay_rdata1) : 8'hFF;
      chk("ay_we1", 16'(ay_we1), 16'(e_we1));
      chk("ay_we2", 16'(ay_we2), 16'(e_we2));
      chk("ay_addr", 16'(ay_addr), 16'(e_addr));
      chk("ay_wdata", 16'(ay_wdata), 16'(e_data));
      chk("init_busy", 16'(init_busy), 16'(m_step < 14));
      chk("d_oe", 16'(d_oe), 16'(io_rd && is_sel(addr)));
      chk("d_out", 16'(d_out), 16'(e_out));
      if (ay_we1 && ay_we2) init_strobes++;
      @(posedge clock);
      if (!reset) model_reset();
      else begin
         if (io_wr && is_sel(addr)) begin
            if (d_in == 8'hFF)           m_sel = 0;
            else if (d_in == 8'hFE)      m_sel = 1;
            else if (d_in < 8'h10) begin m_ra[m_sel] = d_in[3:0]; m_val[m_sel] = 1; end
            else                         m_val[m_sel] = 0;
         end
         if (issue) m_pend = 0;
         if (io_wr && is_data(addr) && m_val[m_sel]) begin
            m_pend = 1; m_pchip = m_sel; m_pa = m_ra[m_sel]; m_pd = d_in;
         end
         if (m_step < 0)                  m_step = 0;
         else if (m_step < 14 && ce)      m_step++;
      end
      #1;
      io_wr = 0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      io_wr = 1; addr = a; d_in = d;
      cyc();
   endtask

   task automatic rd(input logic [15:0] a);
      io_rd = 1; addr = a;
      cyc();
      io_rd = 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic wait_run();
      for (int k = 0; k < 200 && m_step < 14; k++) cyc();
      chk("init_done", 16'(m_step), 16'd14);
   endtask

   initial begin
      model_reset();
      idle(2);
      // pass 1: init with CPU traffic queued while busy
      reset = 1;
      ce_period = 4;
      idle(5);
      wr(16'hFFFD, 8'h05);
      wr(16'hBFFD, 8'hAA);
      idle(3);
      wr(16'hBFFD, 8'hBB);
      wait_run();
      chk("init_strobe_count", 16'(init_strobes), 16'd14);
      idle(8);

      ce_period = 2;
      wr(16'hFFFD, 8'hFE); wr(16'hFFFD, 8'h08); wr(16'hBFFD, 8'h0F); idle(4);
      wr(16'hFFFD, 8'hFF); wr(16'hFFFD, 8'h03); rd(16'hFFFD);
      wr(16'hFFFD, 8'h20); rd(16'hFFFD); wr(16'hBFFD, 8'h11); idle(4);

      // ce stalled: latches move, strobe waits
      ce_period = 0;
      wr(16'hFFFD, 8'h02); wr(16'hBFFD, 8'h77); wr(16'hFFFD, 8'hFE); idle(10);
      ce_period = 3; idle(6);

      // write coinciding with issue of the previous one
      ce_period = 1;
      wr(16'hFFFD, 8'hFF); wr(16'hBFFD, 8'h01); wr(16'hBFFD, 8'h02); idle(3);

      // pass 2: reset in the middle of init step 6
      reset = 0; #1;
      model_reset();
      reset = 1;
      init_strobes = 0;
      ce_period = 4;
      for (int k = 0; k < 200 && m_step < 6; k++) cyc();
      chk("reach_step6", 16'(m_step), 16'd6);
      wr(16'hFFFD, 8'h04); wr(16'hBFFD, 8'h3C);
      reset = 0; #1;
      chk("rst_busy", 16'(init_busy), 16'd1);
      chk("rst_we1", 16'(ay_we1), 16'd0);
      chk("rst_we2", 16'(ay_we2), 16'd0);
      chk("rst_addr", 16'(ay_addr), 16'd0);
      chk("rst_wdata", 16'(ay_wdata), 16'd0);
      chk("rst_d_out", 16'(d_out), 16'h00FF);
      chk("rst_d_oe", 16'(d_oe), 16'd0);
      model_reset();
      init_strobes = 0;
      idle(2);
      reset = 1;
      wait_run();
      chk("restart_strobe_count", 16'(init_strobes), 16'd14);

      // random CPU traffic
      ce_rand = 1;
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 3))
            0: addr = 16'hFFFD;
            1: addr = 16'hBFFD;
            2: addr = 16'h7FFD;
            default: addr = 16'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0: d_in = 8'hFF;
            1: d_in = 8'hFE;
            2: d_in = {4'h0, 4'($urandom)};
            default: d_in = 8'($urandom);
         endcase
         io_rd = 1'($urandom_range(0, 1));
         io_wr = ($urandom_range(0, 9) < 5);
         cyc();
      end
      io_rd = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
